// File: rtl/fir_stream_mac.sv
`default_nettype none
// ============================================================================
//  Module   : fir_stream_mac
//  Brief    : Streaming FIR with loadable coefficients and one shared MAC.
//             Define FIR_SAT_EN to saturate the output instead of truncating.
//  Revision : 1.0  initial release
// ============================================================================
module fir_stream_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 16,
    parameter int OUT_W  = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_wdata,
    input  logic                    flush
);

    localparam int c_idx_w  = $clog2(TAPS);
    localparam int c_prod_w = DATA_W + COEF_W;
    localparam int c_acc_w  = DATA_W + COEF_W + $clog2(TAPS);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mac  = 2'd1;
    localparam logic [1:0] c_st_out  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [DATA_W-1:0]   r_x    [TAPS];
    logic [COEF_W-1:0]   r_coef [TAPS];
    logic [c_acc_w-1:0]  r_acc;
    logic [c_idx_w-1:0]  r_idx;
    logic [OUT_W-1:0]    r_out_data;
    logic [c_prod_w-1:0] w_prod;
    logic [c_acc_w-1:0]  w_sum;
    logic [OUT_W-1:0]    w_result;
    logic                w_last;

    assign w_prod = {{COEF_W{1'b0}}, r_x[r_idx]} * {{DATA_W{1'b0}}, r_coef[r_idx]};
    assign w_sum  = r_acc + {{(c_acc_w - c_prod_w){1'b0}}, w_prod};
    assign w_last = (r_idx == c_idx_w'(TAPS - 1));

`ifdef FIR_SAT_EN
    assign w_result = (|w_sum[c_acc_w-1:OUT_W]) ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];
`else
    assign w_result = w_sum[OUT_W-1:0];
`endif

    assign out_data = r_out_data;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (in_valid)  w_next_state = c_st_mac;
            c_st_mac:  if (w_last)    w_next_state = c_st_out;
            c_st_out:  if (out_ready) w_next_state = c_st_idle;
            default:                  w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_st_idle);
        out_valid = (r_state == c_st_out);
    end

    // Coefficients are only writable between samples so a result never mixes two sets.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k]    <= '0;
                r_coef[k] <= COEF_W'(k + 1);
            end
            r_acc      <= '0;
            r_idx      <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (coef_we && (int'(coef_addr) < TAPS))
                        r_coef[coef_addr] <= coef_wdata;
                    if (in_valid) begin
                        r_x[0] <= in_data;
                        for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
                        r_acc <= '0;
                        r_idx <= '0;
                    end else if (flush) begin
                        for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
                    end
                end
                c_st_mac: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + 1'b1;
                    if (w_last) r_out_data <= w_result;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_stream_mac
//  Brief    : Directed bench for fir_stream_mac against a sum-of-products model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_stream_mac;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int NT = 16;
    localparam int OW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic          coef_we = 1'b0;
    logic [3:0]    coef_addr = '0;
    logic [CW-1:0] coef_wdata = '0;
    logic          flush = 1'b0;

    fir_stream_mac #(.DATA_W(DW), .COEF_W(CW), .TAPS(NT), .OUT_W(OW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .flush(flush)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    longint unsigned mx [NT];
    longint unsigned mc [NT];
    logic [OW-1:0]   exp_q [$];
    logic [OW-1:0]   got   [$];

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic logic [OW-1:0] model_y();
        longint unsigned s = 0;
        longint unsigned lim = (64'd1 << OW) - 1;
        for (int k = 0; k < NT; k++) s += mx[k] * mc[k];
`ifdef FIR_SAT_EN
        if (s > lim) s = lim;
`endif
        return s[OW-1:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NT; k++) begin
            mx[k] = 0;
            mc[k] = longint'(k + 1);
        end
    endtask

    // Every cycle a result is presented it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                check("out_data", out_data, exp_q[0]);
                if (out_ready) begin
                    got.push_back(out_data);
                    void'(exp_q.pop_front());
                end
            end
            check("in_ready_during_out", in_ready, 0);
        end
    end

    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 1, 0);
        end else begin
            for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
            mx[0] = longint'(d);
            exp_q.push_back(model_y());
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("drain_timeout", 1, 0);
    endtask

    task automatic write_coef(input int a, input logic [CW-1:0] v);
        drain();
        @(posedge clk); #1;
        coef_we = 1'b1; coef_addr = 4'(a); coef_wdata = v;
        @(posedge clk); #1;
        coef_we = 1'b0;
        mc[a] = longint'(v);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);

        // Impulse through the default ramp
        got.delete();
        send(16'd1);
        for (int i = 0; i < 16; i++) send(16'd0);
        drain();
        check("imp_count", got.size(), 17);
        if (got.size() == 17) begin
            check("imp_first", got[0], 1);
            check("imp_mid", got[7], 8);
            check("imp_last_tap", got[15], 16);
            check("imp_after", got[16], 0);
        end

        // Step response
        got.delete();
        for (int i = 0; i < 17; i++) send(16'd1);
        drain();
        check("step_count", got.size(), 17);
        if (got.size() == 17) begin
            check("step_0", got[0], 1);
            check("step_2", got[2], 6);
            check("step_15", got[15], 136);
            check("step_16", got[16], 136);
        end

        // Flush, single-tap coefficient set, ignored write during MAC
        drain();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        for (int k = 0; k < NT; k++) mx[k] = 0;
        for (int k = 0; k < NT; k++) write_coef(k, (k == 3) ? 16'd5 : 16'd0);
        got.delete();
        send(16'd7);
        coef_we = 1'b1; coef_addr = 4'd3; coef_wdata = 16'd9;
        repeat (5) @(posedge clk);
        #1 coef_we = 1'b0;
        for (int i = 0; i < 4; i++) send(16'd0);
        drain();
        check("coef_count", got.size(), 5);
        if (got.size() == 5) begin
            check("coef_0", got[0], 0);
            check("coef_3", got[3], 35);
            check("coef_4", got[4], 0);
        end

        for (int k = 0; k < NT; k++) write_coef(k, CW'(k + 1));

        // Backpressure: result held, no new sample until one cycle after handshake
        drain();
        @(posedge clk); #1 out_ready = 1'b0;
        send(16'd3);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_seen", out_valid, 1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'd4;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_held_valid", out_valid, 1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_cycle_ready", in_ready, 0);
        @(negedge clk);
        check("bp_after_hs_ready", in_ready, 1);
        check("bp_after_hs_valid", out_valid, 0);
        for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = 4;
        exp_q.push_back(model_y());
        @(posedge clk); #1 in_valid = 1'b0;
        drain();

        // Full-scale accumulation
        got.delete();
        for (int i = 0; i < 16; i++) send(16'hFFFF);
        drain();
        check("big_count", got.size(), 16);
        if (got.size() == 16) begin
`ifdef FIR_SAT_EN
            check("big_sat", got[15], 1048575);
`else
            check("big_trunc", got[15], 524152);
`endif
        end

        // Reset mid-MAC restores the ramp and clears the line
        write_coef(0, 16'd0);
        send(16'd9);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        got.delete();
        send(16'd1); send(16'd0); send(16'd0);
        drain();
        check("midrst_count", got.size(), 3);
        if (got.size() == 3) begin
            check("midrst_0", got[0], 1);
            check("midrst_1", got[1], 2);
            check("midrst_2", got[2], 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
